// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning the architectural HI/LO registers.
// Multi-cycle multiply, iterative restoring divide with a sign fix-up state.
module mdu_hilo #(
    parameter int WIDTH      = 32,
    parameter int DIV_BITS   = 1,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int ITERS = WIDTH / DIV_BITS;
    localparam int CNT_W = $clog2(ITERS + MUL_STAGES + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ITERS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;      // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] b_q, b_d;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             mul_signed_q, mul_signed_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_nx, rem_nx, quo_fix, rem_fix;
    logic               div_signed;

    // Low 2*WIDTH bits of the sign-extended product are the exact signed result.
    assign prod = {{WIDTH{mul_signed_q & a_q[WIDTH-1]}}, a_q}
                * {{WIDTH{mul_signed_q & b_q[WIDTH-1]}}, b_q};

    assign quo_fix    = quo_neg_q ? -a_q : a_q;
    assign rem_fix    = rem_neg_q ? -rem_q : rem_q;
    assign div_signed = (op_i == OP_DIV);

    always_comb begin : div_step
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] q;
        // NOTE: blocking assignments here are intentional; the loop chains
        // DIV_BITS restoring steps combinationally within one cycle.
        r = {1'b0, rem_q};
        q = a_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, b_q}) begin
                r    = r - {1'b0, b_q};
                q[0] = 1'b1;
            end
        end
        quo_nx = q;
        rem_nx = r[WIDTH-1:0];
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        rem_d        = rem_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_signed_d = mul_signed_q;
        quo_neg_d    = quo_neg_q;
        rem_neg_d    = rem_neg_q;
        dz_d         = dz_q;
        done_d       = 1'b0;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                a_d          = a_i;
                                b_d          = b_i;
                                mul_signed_d = (op_i == OP_MULT);
                                cnt_d        = '0;
                                state_d      = S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_d       = (div_signed && a_i[WIDTH-1]) ? -a_i : a_i;
                                b_d       = (div_signed && b_i[WIDTH-1]) ? -b_i : b_i;
                                rem_d     = '0;
                                quo_neg_d = div_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                                rem_neg_d = div_signed && a_i[WIDTH-1];
                                dz_d      = (b_i == '0);
                                cnt_d     = '0;
                                state_d   = S_DIV;
                            end
                            OP_MTHI: hi_d = a_i;
                            OP_MTLO: lo_d = a_i;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        {hi_d, lo_d} = prod;
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    if (cnt_q == DIV_LAST) state_d = S_FIX;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
                default: begin
                    // A zero divisor still completes, but leaves HI/LO untouched.
                    if (!dz_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_signed_q <= 1'b0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            dz_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_signed_q <= mul_signed_d;
            quo_neg_q    <= quo_neg_d;
            rem_neg_q    <= rem_neg_d;
            dz_q         <= dz_d;
            done_q       <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_mdu_hilo;

    localparam int W          = 32;
    localparam int MUL_STAGES = 2;
    localparam int DIV_LAT    = 33;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start_i = 1'b0, start4 = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         flush_i = 1'b0, flush4 = 1'b0;
    logic         busy_o, done_o, busy4, done4;
    logic [W-1:0] hi_o, lo_o, hi4, lo4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(W), .DIV_BITS(1), .MUL_STAGES(MUL_STAGES)) u_dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    mdu_hilo #(.WIDTH(W), .DIV_BITS(4), .MUL_STAGES(MUL_STAGES)) u_dut4 (
        .clk(clk), .resetn(resetn), .start_i(start4), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush4),
        .busy_o(busy4), .done_o(done4), .hi_o(hi4), .lo_o(lo4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result: {write_enable, HI, LO} from plain integer arithmetic.
    function automatic logic [64:0] model_result(input logic [2:0] op,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        res = '0;
        case (op)
            MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                res = sa * sb;
            end
            MULTU: res = {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == '0) return {1'b0, 64'b0};
                sa = $signed(a);
                sb = $signed(b);
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            default: begin
                if (b == '0) return {1'b0, 64'b0};
                res = {32'(a % b), 32'(a / b)};
            end
        endcase
        return {1'b1, res};
    endfunction

    // Model: countdown of remaining busy cycles; result lands when it expires.
    int           m_left;
    logic         m_wr, m_done;
    logic [63:0]  m_res;
    logic [W-1:0] m_hi, m_lo;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_wr   <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (flush_i) begin
                m_left <= 0;
            end else if (m_left > 0) begin
                if (m_left == 1) begin
                    if (m_wr) {m_hi, m_lo} <= m_res;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end else if (start_i) begin
                case (op_i)
                    MULT, MULTU, DIV, DIVU: begin
                        {m_wr, m_res} <= model_result(op_i, a_i, b_i);
                        m_left <= (op_i == MULT || op_i == MULTU) ? MUL_STAGES : DIV_LAT;
                    end
                    MTHI: m_hi <= a_i;
                    MTLO: m_lo <= a_i;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_hi",   {32'b0, hi_o},   {32'b0, m_hi});
        check("cyc_lo",   {32'b0, lo_o},   {32'b0, m_lo});
        check("cyc_busy", {63'b0, busy_o}, {63'b0, (m_left != 0)});
        check("cyc_done", {63'b0, done_o}, {63'b0, m_done});
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit on4);
        op_i = op;
        a_i  = a;
        b_i  = b;
        if (on4) start4 = 1'b1;
        else     start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        start4  = 1'b0;
    endtask

    task automatic wait_done(input bit on4, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(on4 ? done4 : done_o) && n < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dones;

        #12;
        check("rst_hi",   {32'b0, hi_o},   64'h0);
        check("rst_lo",   {32'b0, lo_o},   64'h0);
        check("rst_busy", {63'b0, busy_o}, 64'h0);
        check("rst_done", {63'b0, done_o}, 64'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue(MULT, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult_busy", {63'b0, busy_o}, 64'h1);
        wait_done(0, n);
        check("mult_lat", n, MUL_STAGES);
        check("mult_hi", {32'b0, hi_o}, 64'hFFFF_FFFF);
        check("mult_lo", {32'b0, lo_o}, 64'hFFFF_FFFE);
        check("mult_busy_done", {63'b0, busy_o}, 64'h0);
        @(posedge clk);
        #1;
        check("mult_done_drop", {63'b0, done_o}, 64'h0);

        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        wait_done(0, n);
        check("multu_hi", {32'b0, hi_o}, 64'h1);
        check("multu_lo", {32'b0, lo_o}, 64'hFFFF_FFFE);

        issue(DIV, 32'hFFFF_FFF9, 32'd2, 0);
        wait_done(0, n);
        check("div_lat", n, 33);
        check("div_lo", {32'b0, lo_o}, 64'hFFFF_FFFD);
        check("div_hi", {32'b0, hi_o}, 64'hFFFF_FFFF);

        // Back-to-back: start in the done cycle.
        issue(DIVU, 32'd100, 32'd7, 0);
        wait_done(0, n);
        check("divu_lat", n, 33);
        check("divu_lo", {32'b0, lo_o}, 64'd14);
        check("divu_hi", {32'b0, hi_o}, 64'd2);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_done(0, n);
        check("divmin_lo", {32'b0, lo_o}, 64'h8000_0000);
        check("divmin_hi", {32'b0, hi_o}, 64'h0);

        issue(MTHI, 32'h1234, 32'd0, 0);
        check("mthi_hi",   {32'b0, hi_o},   64'h1234);
        check("mthi_busy", {63'b0, busy_o}, 64'h0);
        issue(MTLO, 32'h5678, 32'd0, 0);
        check("mtlo_lo", {32'b0, lo_o}, 64'h5678);
        check("mtlo_done", {63'b0, done_o}, 64'h0);

        issue(DIVU, 32'd55, 32'd0, 0);
        wait_done(0, n);
        check("dz_lat", n, 33);
        check("dz_done", {63'b0, done_o}, 64'h1);
        check("dz_hi", {32'b0, hi_o}, 64'h1234);
        check("dz_lo", {32'b0, lo_o}, 64'h5678);

        // Flush partway through the divide iterations.
        issue(DIVU, 32'd1000, 32'd3, 0);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_busy", {63'b0, busy_o}, 64'h0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        check("flush_no_done", dones, 0);
        check("flush_hi", {32'b0, hi_o}, 64'h1234);
        check("flush_lo", {32'b0, lo_o}, 64'h5678);

        // Flush and start together: nothing accepted.
        flush_i = 1'b1;
        issue(MULT, 32'd3, 32'd5, 0);
        flush_i = 1'b0;
        check("fs_busy", {63'b0, busy_o}, 64'h0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        check("fs_no_done", dones, 0);
        check("fs_lo", {32'b0, lo_o}, 64'h5678);

        // Requests while busy are dropped.
        issue(MULT, 32'h0001_0000, 32'h0001_0000, 0);
        issue(MTHI, 32'hAAAA, 32'd0, 0);
        issue(DIV, 32'd100, 32'd7, 0);
        check("busy_ign_done", {63'b0, done_o}, 64'h1);
        check("busy_ign_hi", {32'b0, hi_o}, 64'h1);
        check("busy_ign_lo", {32'b0, lo_o}, 64'h0);
        @(posedge clk);
        #1;
        check("busy_ign_idle", {63'b0, busy_o}, 64'h0);

        // Asynchronous reset in the middle of a divide.
        issue(DIVU, 32'd100, 32'd7, 0);
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_hi",   {32'b0, hi_o},   64'h0);
        check("arst_lo",   {32'b0, lo_o},   64'h0);
        check("arst_busy", {63'b0, busy_o}, 64'h0);
        check("arst_done", {63'b0, done_o}, 64'h0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        issue(MULTU, 32'd3, 32'd5, 0);
        wait_done(0, n);
        check("post_rst_lo", {32'b0, lo_o}, 64'd15);
        check("post_rst_hi", {32'b0, hi_o}, 64'd0);

        // Four quotient bits per iteration.
        issue(DIVU, 32'd100, 32'd7, 1);
        wait_done(1, n);
        check("db4_lat", n, 9);
        check("db4_lo", {32'b0, lo4}, 64'd14);
        check("db4_hi", {32'b0, hi4}, 64'd2);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(1, n);
        check("db4_div_lo", {32'b0, lo4}, 64'hFFFF_FFFD);
        check("db4_div_hi", {32'b0, hi4}, 64'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multiply/divide unit owning the architectural HI/LO registers of the mycpu core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, the R-type functions that the decode stage recognises but the single-cycle ALU cannot complete. It sits beside the execute-stage ALU and drives a busy signal the hazard unit uses to stall, plus HI/LO values read by MFHI/MFLO. Multiply is pipelined over a configurable number of cycles; divide is iterative with configurable quotient bits per cycle.

## Interface
- WIDTH, 32, operand and HI/LO width
- DIV_BITS, 1, quotient bits retired per divide iteration; legal 1, 2, 4; must divide WIDTH
- MUL_STAGES, 2, multiply latency in cycles; legal 1..4
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start_i  in  1  request valid this cycle
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored
- a_i  in  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
- b_i  in  WIDTH  rt value (multiplier / divisor)
- flush_i  in  1  abort in-flight operation (exception or pipeline flush)
- busy_o  out  1  operation in flight; new start_i ignored
- done_o  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV family
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

## Operation
- States: IDLE, MUL, DIV, FIX. Reset: IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counters 0.
- Request accepted at an edge only when start_i=1, busy_o=0, flush_i=0; op_i 6–7 accepted as no-op.
- MTHI/MTLO: HI (resp. LO) ← a_i at the accepting edge; stays IDLE; no done_o; busy_o stays 0.
- MULT/MULTU: operands latched; IDLE→MUL; 2·WIDTH product, signed (MULT) or unsigned (MULTU); {HI,LO} ← product.
- DIV/DIVU: operands latched as magnitudes (DIV: absolute values, signs recorded); IDLE→DIV; restoring division, DIV_BITS quotient bits per cycle for WIDTH/DIV_BITS cycles; then FIX applies signs: quotient negated iff signs differ, remainder takes dividend sign (truncation toward zero). LO ← quotient, HI ← remainder.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor zero: full latency still taken, done_o still pulses, HI/LO unchanged.
- Completion writes HI/LO, returns IDLE, done_o=1 for exactly the following cycle.
- flush_i=1 in any state: next edge → IDLE, HI/LO unchanged, no done_o; flush_i with start_i same cycle: flush wins, nothing accepted.
- start_i while busy_o=1: ignored, not queued; MTHI/MTLO while busy likewise ignored.
- resetn low mid-operation: immediate return to reset values regardless of clk.

## Timing
- Accepting edge E. busy_o=1 from E through the completing edge's preceding cycle; busy_o combinationally 0 in IDLE.
- MULT/MULTU: HI/LO valid and done_o=1 in cycle after edge E+MUL_STAGES; busy_o=0 that same cycle.
- DIV/DIVU: completion edge E+WIDTH/DIV_BITS+1 (iterations plus FIX); 33 cycles at DIV_BITS=1, 9 at DIV_BITS=4.
- Back-to-back: start_i in the done_o cycle is accepted (busy_o=0).
- MTHI/MTLO: hi_o/lo_o updated in cycle after E.
- hi_o/lo_o are direct register outputs; no combinational path from inputs.

## Test plan
- Reset, then MULT a=0xFFFFFFFF b=2 (MUL_STAGES=2) -> hi=0xFFFFFFFF lo=0xFFFFFFFE, done_o pulse 2 cycles after accept; MULTU same -> hi=1 lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14 hi=2, latency 33 (DIV_BITS=1) and 9 (DIV_BITS=4).
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU with b=0 after MTHI 0x1234/MTLO 0x5678 -> HI/LO stay 0x1234/0x5678, done_o still pulses.
- Start DIVU, assert flush_i at iteration 10 -> busy_o low next cycle, no done_o, HI/LO unchanged; flush_i with start_i same cycle -> no operation starts.
- During busy MULT issue MTHI 0xAAAA and another DIV -> both ignored; final hi/lo equal the MULT product only.
- Deassert resetn mid-DIV asynchronously -> hi_o=lo_o=0, busy_o=done_o=0 immediately; new MULTU 3×5 after release -> lo=15 hi=0.
